// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared FSM state encoding and bus mode constants for the bus master arbiter.
package cpu_bus_pkg;
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  localparam logic BUS_MODE_READ  = 1'b0;
  localparam logic BUS_MODE_WRITE = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the one-hot last grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] grant
);
  logic [N-1:0] hi;
  logic [N-1:0] masked;
  always_comb begin
    // hi keeps only channels strictly above last; if none request, wrap to the lowest requester
    hi = ~((last << 1) - N'(1));
    masked = req & hi;
    grant = |masked ? masked & (~masked + N'(1)) : req & (~req + N'(1));
  end
endmodule

// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin arbitration of NUM_CH requesters onto one BUS_* handshake,
// with per-transfer timeout ending a hung transfer with an error response.
module bus_master_arb
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_mode,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [ADDR_W-1:0]        BUS_addr,
  output logic [DATA_W-1:0]        BUS_wdata,
  input  logic [DATA_W-1:0]        BUS_rdata,
  output logic                     BUS_valid,
  output logic                     BUS_mode,
  input  logic                     BUS_wready,
  output logic                     BUS_rready,
  input  logic                     BUS_rvalid
);
  localparam int CW = TIMEOUT == 0 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [NUM_CH-1:0] LAST_RST = NUM_CH'(1) << (NUM_CH - 1);

  state_t state, state_n;
  logic [NUM_CH-1:0] grant, last_q, g_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic mode_q, err_q, done, tmo;
  logic [CW-1:0] cnt;
  logic [NUM_CH:0][ADDR_W-1:0] addr_acc;
  logic [NUM_CH:0][DATA_W-1:0] wdata_acc;
  logic [NUM_CH:0] mode_acc;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // grant is one-hot, so OR-ing the masked channels acts as the request mux
  assign addr_acc[0]  = '0;
  assign wdata_acc[0] = '0;
  assign mode_acc[0]  = 1'b0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_mux
    assign addr_acc[i+1]  = addr_acc[i]  | (grant[i] ? req_addr[i*ADDR_W +: ADDR_W]  : '0);
    assign wdata_acc[i+1] = wdata_acc[i] | (grant[i] ? req_wdata[i*DATA_W +: DATA_W] : '0);
    assign mode_acc[i+1]  = mode_acc[i]  | (grant[i] & req_mode[i]);
  end

  always_comb begin
    done = state == XFER && (mode_q == BUS_MODE_WRITE ? BUS_wready : BUS_rvalid);
    tmo = TIMEOUT != 0 && state == XFER && cnt == CNT_LIM;
    state_n = state == IDLE ? (|req_valid ? XFER : IDLE) :
              state == XFER ? (done || tmo ? RESP : XFER) : IDLE;
    req_ready = state == IDLE ? grant : '0;
    rsp_valid = state == RESP ? g_q : '0;
    busy = state != IDLE;
    BUS_valid = state == XFER;
    BUS_mode = state == XFER && mode_q == BUS_MODE_WRITE;
    BUS_rready = state == XFER && mode_q == BUS_MODE_READ;
    BUS_addr = addr_q;
    BUS_wdata = wdata_q;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_q  <= LAST_RST;
      g_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= BUS_MODE_READ;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_valid) begin
        addr_q  <= addr_acc[NUM_CH];
        wdata_q <= wdata_acc[NUM_CH];
        mode_q  <= mode_acc[NUM_CH];
        g_q     <= grant;
        last_q  <= grant;
        cnt     <= '0;
      end
      if (state == XFER && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      // a completing handshake takes precedence over a simultaneous timeout
      if (done || tmo) begin
        rdata_q <= done && mode_q == BUS_MODE_READ ? BUS_rdata : '0;
        err_q   <= !done;
      end
    end
  end
endmodule
